// File: rtl/gpio_serial_pkg.sv
// Shared types and defaults for the padframe serial configuration loader.
package gpio_serial_pkg;

    localparam int unsigned GPIO_CFG_BITS_DEFAULT = 13;
    localparam int unsigned GPIO_NUM_PADS_DEFAULT = 44;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        LATCH,
        DONE
    } gpio_ser_state_t;

    // Counter width that stays legal when the range collapses to a single value.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gpio_serial_clkdiv.sv
// Half-period timer for the serial shift clock: phase bit, phase_end and rise strobes.
// The rise strobe exists only when GPIO_SERIAL_READBACK_EN is defined.
module gpio_serial_clkdiv
    import gpio_serial_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
`ifdef GPIO_SERIAL_READBACK_EN
    output logic rise,
`endif
    output logic phase,
    output logic phase_end
);

    localparam int unsigned DIV_W = cnt_width(CLK_DIV);

    logic [DIV_W-1:0] div_cnt;

    assign phase_end = enable && (div_cnt == DIV_W'(CLK_DIV - 1));

`ifdef GPIO_SERIAL_READBACK_EN
    // First cycle of the high phase, i.e. the cycle ser_clk reads 1 for the first time.
    assign rise = enable && phase && (div_cnt == '0);
`endif

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            div_cnt <= '0;
            phase   <= 1'b0;
        end else if (phase_end) begin
            div_cnt <= '0;
            phase   <= ~phase;
        end else if (enable) begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/gpio_serial_loader.sv
// Loads one configuration word per pad MSB-first onto the pad-ring chain, then strobes ser_load.
// Optional chain readback is compiled in with GPIO_SERIAL_READBACK_EN.
//
// state | meaning
// IDLE  | waiting for start, outputs quiet
// LOAD  | cfg_ready high, waiting for the next pad word
// SHIFT | clocking the captured word out, two phases per bit
// LATCH | ser_load high for one full ser_clk period
// DONE  | one-cycle done pulse
module gpio_serial_loader
    import gpio_serial_pkg::*;
#(
    parameter int unsigned NUM_PADS = GPIO_NUM_PADS_DEFAULT,
    parameter int unsigned CFG_BITS = GPIO_CFG_BITS_DEFAULT,
    parameter int unsigned CLK_DIV  = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                cfg_valid,
    input  logic [CFG_BITS-1:0] cfg_data,
`ifdef GPIO_SERIAL_READBACK_EN
    input  logic                ser_ret,
    output logic [CFG_BITS-1:0] rb_data,
    output logic                rb_valid,
`endif
    output logic                cfg_ready,
    output logic                busy,
    output logic                done,
    output logic                ser_data,
    output logic                ser_clk,
    output logic                ser_load
);

    localparam int unsigned PAD_W = cnt_width(NUM_PADS);
    localparam int unsigned BIT_W = cnt_width(CFG_BITS);

    gpio_ser_state_t     state;
    logic [PAD_W-1:0]    pad_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [CFG_BITS-1:0] shreg;
    logic [CFG_BITS-1:0] shreg_next;
    logic                phase;
    logic                phase_end;
    logic                accept;
    logic                bit_end;
    logic                last_bit;
    logic                last_pad;

    assign accept     = (state == LOAD) && cfg_valid && cfg_ready;
    assign bit_end    = (state == SHIFT) && phase_end && phase;
    assign last_bit   = (bit_cnt == BIT_W'(CFG_BITS - 1));
    assign last_pad   = (pad_cnt == PAD_W'(NUM_PADS - 1));
    assign shreg_next = shreg << 1;

`ifdef GPIO_SERIAL_READBACK_EN
    logic rise;
`endif

    gpio_serial_clkdiv #(
        .CLK_DIV (CLK_DIV)
    ) u_clkdiv (
        .clock     (clock),
        .reset     (reset),
        .enable    ((state == SHIFT) || (state == LATCH)),
        .clear     (accept),
`ifdef GPIO_SERIAL_READBACK_EN
        .rise      (rise),
`endif
        .phase     (phase),
        .phase_end (phase_end)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            pad_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            cfg_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ser_data  <= 1'b0;
            ser_clk   <= 1'b0;
            ser_load  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= LOAD;
                        pad_cnt   <= '0;
                        cfg_ready <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        state     <= SHIFT;
                        shreg     <= cfg_data;
                        bit_cnt   <= '0;
                        cfg_ready <= 1'b0;
                        ser_data  <= cfg_data[CFG_BITS-1];
                        ser_clk   <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (phase_end && !phase) begin
                        ser_clk <= 1'b1;
                    end else if (bit_end) begin
                        ser_clk <= 1'b0;
                        shreg   <= shreg_next;
                        if (!last_bit) begin
                            bit_cnt  <= bit_cnt + BIT_W'(1);
                            ser_data <= shreg_next[CFG_BITS-1];
                        end else if (last_pad) begin
                            state    <= LATCH;
                            ser_load <= 1'b1;
                        end else begin
                            state     <= LOAD;
                            pad_cnt   <= pad_cnt + PAD_W'(1);
                            cfg_ready <= 1'b1;
                        end
                    end
                end
                LATCH: begin
                    if (phase_end && phase) begin
                        state    <= DONE;
                        ser_load <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    ser_data <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef GPIO_SERIAL_READBACK_EN
    logic [CFG_BITS-1:0] rb_shreg;
    logic [CFG_BITS-1:0] rb_next;
    logic                capture;

    assign capture = rise && (state == SHIFT);
    assign rb_next = {rb_shreg[CFG_BITS-2:0], ser_ret};

    // With CLK_DIV=1 the last rise and the word end share a cycle, so forward the fresh bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            rb_shreg <= '0;
            rb_data  <= '0;
            rb_valid <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            if (capture) begin
                rb_shreg <= rb_next;
            end
            if (bit_end && last_bit) begin
                rb_valid <= 1'b1;
                rb_data  <= capture ? rb_next : rb_shreg;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Directed bench for gpio_serial_loader with NUM_PADS=2, CFG_BITS=13, CLK_DIV=2.
// Readback checks are included when GPIO_SERIAL_READBACK_EN is defined.
module tb_gpio_serial_loader;

    localparam int NP = 2;
    localparam int CB = 13;
    localparam int CD = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [CB-1:0] cfg_data = '0;
    logic          cfg_ready;
    logic          busy;
    logic          done;
    logic          ser_data;
    logic          ser_clk;
    logic          ser_load;

    int total = 0;
    int bad   = 0;

    logic [CB-1:0] words [2];
    localparam logic [25:0] EXP_STREAM = {13'h1A5A, 13'h0F0F};

`ifdef GPIO_SERIAL_READBACK_EN
    logic          ser_ret;
    logic [CB-1:0] rb_data;
    logic          rb_valid;
    logic [25:0]   chain;
    logic          din;
    int            rb_cnt;
    logic [CB-1:0] rb_got [2];

    // Model chain: samples data on the ser_clk rise, moves it on the fall so the tail is stable at the rise.
    assign ser_ret = chain[25];
    always @(posedge ser_clk) din = ser_data;
    always @(negedge ser_clk) chain = {chain[24:0], din};
`endif

    always #5 clock = ~clock;

    gpio_serial_loader #(
        .NUM_PADS (NP),
        .CFG_BITS (CB),
        .CLK_DIV  (CD)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
`ifdef GPIO_SERIAL_READBACK_EN
        .ser_ret   (ser_ret),
        .rb_data   (rb_data),
        .rb_valid  (rb_valid),
`endif
        .cfg_ready (cfg_ready),
        .busy      (busy),
        .done      (done),
        .ser_data  (ser_data),
        .ser_clk   (ser_clk),
        .ser_load  (ser_load)
    );

    // Runs one full load from start; k counts cycles after the start cycle.
    task automatic drive_load(input int stall, input bit poke,
                              output int done_cyc, output logic [25:0] stream,
                              output int nrise, output int nload,
                              output int first_load, output int nbad);
        int   idx;
        int   left;
        logic prev_clk;
        idx = 0; left = stall; done_cyc = -1; stream = '0;
        nrise = 0; nload = 0; first_load = -1; nbad = 0; prev_clk = 1'b0;
`ifdef GPIO_SERIAL_READBACK_EN
        rb_cnt = 0;
`endif
        @(negedge clock);
        start = 1'b1;
        cfg_valid = 1'b0;
        for (int k = 1; k <= 400 && done_cyc < 0; k++) begin
            @(negedge clock);
            start = poke && (k == 20);
            if (ser_clk && !prev_clk) begin
                stream = {stream[24:0], ser_data};
                nrise++;
            end
            prev_clk = ser_clk;
            if (ser_load) begin
                nload++;
                if (first_load < 0) first_load = k;
            end
            if (done) done_cyc = k;
            else if (!busy) nbad++;
`ifdef GPIO_SERIAL_READBACK_EN
            if (rb_valid) begin
                if (rb_cnt < 2) rb_got[rb_cnt] = rb_data;
                rb_cnt++;
            end
`endif
            if (idx == 1 && left > 0 && left < stall && !cfg_ready) nbad++;
            if (cfg_ready && idx < 2) begin
                if (idx == 1 && left > 0) begin
                    cfg_valid = 1'b0;
                    left--;
                    if (ser_clk) nbad++;
                end else begin
                    cfg_valid = 1'b1;
                    cfg_data  = words[idx];
                    idx++;
                end
            end else begin
                cfg_valid = 1'b1;
                cfg_data  = poke ? 13'h1FFF : words[(idx == 0) ? 0 : 1];
            end
        end
        start = 1'b0;
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        total++;
        if ({cfg_ready, busy, done, ser_data, ser_clk, ser_load} !== 6'b0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 000000",
                     {cfg_ready, busy, done, ser_data, ser_clk, ser_load});
        end
        reset = 1'b0;
        @(negedge clock);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_basic();
        int dc, nr, nl, fl, nb;
        logic [25:0] st;
        drive_load(0, 1'b0, dc, st, nr, nl, fl, nb);
        total++;
        if (dc !== 111) begin bad++; $display("FAIL basic_done_cycle: got %0d want 111", dc); end
        total++;
        if (st !== EXP_STREAM) begin bad++; $display("FAIL basic_stream: got %b want %b", st, EXP_STREAM); end
        total++;
        if (nr !== 26) begin bad++; $display("FAIL basic_rise_count: got %0d want 26", nr); end
        total++;
        if (nl !== 4) begin bad++; $display("FAIL basic_load_len: got %0d want 4", nl); end
        total++;
        if (fl !== 107) begin bad++; $display("FAIL basic_load_start: got %0d want 107", fl); end
        total++;
        if (nb !== 0) begin bad++; $display("FAIL basic_busy: got %0d drops want 0", nb); end
        @(negedge clock);
        total++;
        if ({busy, done, ser_data, ser_clk, ser_load, cfg_ready} !== 6'b0) begin
            bad++;
            $display("FAIL basic_back_idle: got %b want 000000",
                     {busy, done, ser_data, ser_clk, ser_load, cfg_ready});
        end
    endtask

    task automatic test_stall();
        int dc, nr, nl, fl, nb;
        logic [25:0] st;
        drive_load(10, 1'b0, dc, st, nr, nl, fl, nb);
        total++;
        if (dc !== 121) begin bad++; $display("FAIL stall_done_cycle: got %0d want 121", dc); end
        total++;
        if (nb !== 0) begin bad++; $display("FAIL stall_ready_clk: got %0d violations want 0", nb); end
        total++;
        if (st !== EXP_STREAM) begin bad++; $display("FAIL stall_stream: got %b want %b", st, EXP_STREAM); end
        @(negedge clock);
    endtask

    task automatic test_ignored();
        int dc, nr, nl, fl, nb;
        logic [25:0] st;
        drive_load(0, 1'b1, dc, st, nr, nl, fl, nb);
        total++;
        if (dc !== 111) begin bad++; $display("FAIL ignored_done_cycle: got %0d want 111", dc); end
        total++;
        if (nr !== 26) begin bad++; $display("FAIL ignored_rise_count: got %0d want 26", nr); end
        total++;
        if (st !== EXP_STREAM) begin bad++; $display("FAIL ignored_stream: got %b want %b", st, EXP_STREAM); end
        total++;
        if (nb !== 0) begin bad++; $display("FAIL ignored_busy: got %0d drops want 0", nb); end
        @(negedge clock);
    endtask

    task automatic test_reset_mid();
        int dc, nr, nl, fl, nb, nlate;
        logic [25:0] st;
        @(negedge clock);
        start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data = 13'h1A5A;
        for (int k = 1; k <= 26; k++) begin
            @(negedge clock);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        total++;
        if ({cfg_ready, busy, done, ser_data, ser_clk, ser_load} !== 6'b0) begin
            bad++;
            $display("FAIL midreset_outputs: got %b want 000000",
                     {cfg_ready, busy, done, ser_data, ser_clk, ser_load});
        end
        nlate = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            if (ser_load || busy) nlate++;
        end
        cfg_valid = 1'b0;
        total++;
        if (nlate !== 0) begin bad++; $display("FAIL midreset_no_latch: got %0d active cycles want 0", nlate); end
        drive_load(0, 1'b0, dc, st, nr, nl, fl, nb);
        total++;
        if (dc !== 111) begin bad++; $display("FAIL midreset_reload_done: got %0d want 111", dc); end
        total++;
        if (st !== EXP_STREAM) begin bad++; $display("FAIL midreset_reload_stream: got %b want %b", st, EXP_STREAM); end
        @(negedge clock);
    endtask

`ifdef GPIO_SERIAL_READBACK_EN
    task automatic test_readback();
        int dc, nr, nl, fl, nb;
        logic [25:0] st;
        chain = {13'h0AAA, 13'h1555};
        drive_load(0, 1'b0, dc, st, nr, nl, fl, nb);
        total++;
        if (rb_cnt !== 2) begin bad++; $display("FAIL rb_pulses: got %0d want 2", rb_cnt); end
        total++;
        if (rb_got[0] !== 13'h0AAA) begin bad++; $display("FAIL rb_word0: got %h want 0aaa", rb_got[0]); end
        total++;
        if (rb_got[1] !== 13'h1555) begin bad++; $display("FAIL rb_word1: got %h want 1555", rb_got[1]); end
        total++;
        if (chain !== EXP_STREAM) begin bad++; $display("FAIL rb_chain_contents: got %b want %b", chain, EXP_STREAM); end
        @(negedge clock);
    endtask
`endif

    initial begin
        words[0] = 13'h1A5A;
        words[1] = 13'h0F0F;
        test_reset();
        test_basic();
        test_stall();
        test_ignored();
        test_reset_mid();
`ifdef GPIO_SERIAL_READBACK_EN
        test_readback();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
